// File: rtl/fifo_uart_tx.sv
// UART transmitter fed by a first-word-fall-through FIFO.
// One serial bit per clock; optional even/odd parity; back-to-back frames.
module fifo_uart_tx #(
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] rd_data,
    input  logic                  empty,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  r_inc,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int cw = (data_width > 1) ? $clog2(data_width) : 1;
    localparam logic [cw-1:0] last = cw'(data_width - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    logic [data_width-1:0] data_q;
    logic [data_width-1:0] data_nxt;
    logic [cw-1:0]         cnt;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  cap;

    // A pop is only legal when the line is free or finishing its stop bit.
    assign cap = rst && !empty && (state == IDLE || state == STOP);
    assign r_inc = cap;
    assign data_nxt = data_q >> 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tx_out    <= 1'b1;
            busy      <= 1'b0;
            cnt       <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            if (cap) begin
                data_q    <= rd_data;
                par_en_q  <= par_en;
                par_bit_q <= (^rd_data) ^ par_typ;
            end
            unique case (state)
                IDLE, STOP: begin
                    if (cap) begin
                        state  <= START;
                        tx_out <= 1'b0;
                        busy   <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        tx_out <= 1'b1;
                        busy   <= 1'b0;
                    end
                end
                START: begin
                    state  <= DATA;
                    tx_out <= data_q[0];
                    cnt    <= '0;
                end
                DATA: begin
                    if (cnt == last) begin
                        cnt <= '0;
                        if (par_en_q) begin
                            state  <= PARITY;
                            tx_out <= par_bit_q;
                        end else begin
                            state  <= STOP;
                            tx_out <= 1'b1;
                        end
                    end else begin
                        // Shift so the next bit always sits at index 0.
                        cnt    <= cnt + 1'b1;
                        data_q <= data_nxt;
                        tx_out <= data_nxt[0];
                    end
                end
                PARITY: begin
                    state  <= STOP;
                    tx_out <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter: data_width, default 8, width of FIFO read data and of the serial payload.
REQ-002 Port: clk  input  1  block clock; same clock as the FIFO read domain (r_clk); all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-low.
REQ-004 Port: rd_data  input  data_width  FIFO read data; first-word-fall-through, valid whenever empty=0.
REQ-005 Port: empty  input  1  FIFO empty flag, synchronous to clk.
REQ-006 Port: par_en  input  1  parity enable; 1 = parity bit inserted.
REQ-007 Port: par_typ  input  1  parity type; 0 = even, 1 = odd.
REQ-008 Port: r_inc  output  1  FIFO pop strobe; one-cycle pulse per byte consumed.
REQ-009 Port: tx_out  output  1  serial line; idle high; registered.
REQ-010 Port: busy  output  1  high while a frame is in flight; registered.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; one serial bit per clk cycle.
REQ-012 Capture cycle: in IDLE or in STOP with empty=0; r_inc=1 combinationally in that cycle only; rd_data, par_en, par_typ latched at the closing edge.
REQ-013 r_inc SHALL be 0 in every other cycle, including whenever empty=1.
REQ-014 IDLE: tx_out=1, busy=0; on capture -> START; else stay IDLE.
REQ-015 START: tx_out=0 for one cycle, busy=1 -> DATA.
REQ-016 DATA: data_width cycles, tx_out = latched bit LSB first; counter 0..data_width-1; at last bit -> PARITY if latched par_en=1, else STOP.
REQ-017 PARITY: one cycle; tx_out = XOR of latched data when par_typ=0, its inverse when par_typ=1 -> STOP.
REQ-018 STOP: tx_out=1 for one cycle; with capture -> START (back-to-back, no idle gap, busy stays 1); else -> IDLE.
REQ-019 Latency: capture in cycle N -> start bit visible on tx_out in cycle N+1.
REQ-020 Frame length: 1+data_width+par_en+1 cycles; consecutive frames in STOP-to-START chaining SHALL have no extra cycles.
REQ-021 par_en/par_typ changes mid-frame SHALL NOT affect the frame in flight; they apply from the next capture.
REQ-022 empty rising mid-frame SHALL NOT affect the frame in flight; the block returns to IDLE after STOP.
REQ-023 Exactly one r_inc pulse per transmitted frame; no pop without a subsequent frame.

Reset
REQ-024 rst=0 SHALL immediately force state=IDLE, tx_out=1, busy=0, r_inc=0, bit counter=0, data latch=0.
REQ-025 Reset mid-frame aborts the frame; tx_out returns high without completing the stop bit; the popped byte is discarded.
REQ-026 After rst release, the first capture SHALL occur no earlier than the first rising edge with rst=1 and empty=0.

Verification
REQ-027 Single byte, no parity: empty=0 with rd_data=0xA5 for one pop -> one r_inc pulse; tx_out = 0,1,0,1,0,0,1,0,1,1 then idle high; busy high exactly 10 cycles.
REQ-028 Even parity: par_en=1, par_typ=0, rd_data=0x07 -> data bits 1,1,1,0,0,0,0,0, parity=1, 11-cycle frame; repeat with par_typ=1 -> parity=0.
REQ-029 Back-to-back: FIFO holds 0x00, 0xFF -> r_inc pulses exactly 10 cycles apart; second start bit immediately follows first stop bit; busy never drops between frames.
REQ-030 Config change mid-frame: par_en toggled 0->1 during DATA of byte 0x3C -> that frame is 10 cycles, no parity; next frame is 11 cycles.
REQ-031 Reset mid-frame: assert rst during DATA bit 3 -> tx_out=1, busy=0, r_inc=0 asynchronously; after release with empty=0 the next byte transmits as a full frame.
REQ-032 Empty hold: empty=1 for 50 cycles after reset -> r_inc=0, tx_out=1, busy=0 throughout.
